// File: rtl/global_history_updater.sv
// Speculative global-history writer: shifts predicted outcomes into the
// speculative history and keeps an in-order FIFO of pre-branch snapshots.
// A mispredicted branch restores its snapshot with the actual outcome
// shifted in. Every history change is forwarded to the GHR through a
// registered write strobe and registered data.
module global_history_updater #(
    parameter int HIST_WIDTH = 128,
    parameter int DEPTH      = 4
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_predict_valid,
    input  logic                         i_predict_taken,
    input  logic                         i_resolve_valid,
    input  logic                         i_resolve_taken,
    input  logic                         i_resolve_mispredict,
    output logic                         o_stall,
    output logic                         o_hist_write,
    output logic [HIST_WIDTH-1:0]        o_hist_datain,
    output logic [HIST_WIDTH-1:0]        o_spec_history,
    output logic [$clog2(DEPTH+1)-1:0]   o_inflight_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [HIST_WIDTH-1:0] r_fifo [DEPTH];
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_wr_ptr;
    logic [CW-1:0]         r_count;
    logic [HIST_WIDTH-1:0] r_spec;
    logic                  r_hist_write;
    logic [HIST_WIDTH-1:0] r_hist_datain;

    logic                  w_run;
    logic                  w_full;
    logic                  w_resolve;
    logic                  w_mispredict;
    logic                  w_pop;
    logic                  w_push;
    logic [HIST_WIDTH-1:0] w_oldest;
    logic [HIST_WIDTH-1:0] w_next_spec;

    // Newest outcome enters at the LSB; the oldest bit falls off the MSB.
    function automatic logic [HIST_WIDTH-1:0] f_shift(input logic [HIST_WIDTH-1:0] hist,
                                                      input logic                  taken);
        return {hist[HIST_WIDTH-2:0], taken};
    endfunction

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Decode what this cycle does: resolves win over predicts, and a full FIFO
    // still accepts a predict when the same cycle frees an entry.
    always_comb begin
        w_run        = (r_state == ST_RUN);
        w_full       = (r_count == CW'(DEPTH));
        w_resolve    = w_run & i_resolve_valid & (r_count != '0);
        w_mispredict = w_resolve & i_resolve_mispredict;
        w_pop        = w_resolve & ~i_resolve_mispredict;
        w_push       = w_run & i_predict_valid & ~w_mispredict & (~w_full | w_pop);
        w_oldest     = r_fifo[r_rd_ptr];
        w_next_spec  = r_spec;
        if (w_mispredict) begin
            w_next_spec = f_shift(w_oldest, i_resolve_taken);
        end else if (w_push) begin
            w_next_spec = f_shift(r_spec, i_predict_taken);
        end
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= ST_RUN;
        else         r_state <= w_next_state;
    end

    // Next-state logic: a mispredict costs exactly one recovery cycle.
    always_comb begin
        w_next_state = ST_RUN;
        if (w_mispredict) w_next_state = ST_RECOVER;
    end

    // Output logic: fetch is held off while recovering or when no checkpoint is free.
    always_comb begin
        o_stall = (r_state == ST_RECOVER) | w_full;
    end

    // Checkpoint storage; the occupancy pointers alone decide what is valid.
    always_ff @(posedge i_clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= r_spec;
    end

    // FIFO pointers, occupancy, speculative history and the GHR write port.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_spec        <= '0;
            r_hist_write  <= 1'b0;
            r_hist_datain <= '0;
        end else begin
            if (w_mispredict) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_pop)  r_rd_ptr <= f_ptr_inc(r_rd_ptr);
                if (w_push) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
            r_spec        <= w_next_spec;
            r_hist_write  <= (w_next_spec != r_spec);
            r_hist_datain <= w_next_spec;
        end
    end

    assign o_hist_write     = r_hist_write;
    assign o_hist_datain    = r_hist_datain;
    assign o_spec_history   = r_spec;
    assign o_inflight_count = r_count;

endmodule

// File: tb/tb_global_history_updater.sv
// Bench for global_history_updater: directed scenarios plus random traffic,
// all checked against a queue-based reference model of the history rules.
module tb_global_history_updater;

    localparam int HW = 8;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pv = 1'b0, pt = 1'b0, rv = 1'b0, rt = 1'b0, rm = 1'b0;
    logic          stall, hist_write;
    logic [HW-1:0] hist_datain, spec_history;
    logic [2:0]    inflight_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [HW-1:0] m_spec;
    logic [HW-1:0] m_q[$];
    bit            m_rec;
    bit            m_hw;
    logic [HW-1:0] m_din;

    global_history_updater #(.HIST_WIDTH(HW), .DEPTH(DP)) dut (
        .i_clk                (clk),
        .i_reset              (reset),
        .i_predict_valid      (pv),
        .i_predict_taken      (pt),
        .i_resolve_valid      (rv),
        .i_resolve_taken      (rt),
        .i_resolve_mispredict (rm),
        .o_stall              (stall),
        .o_hist_write         (hist_write),
        .o_hist_datain        (hist_datain),
        .o_spec_history       (spec_history),
        .o_inflight_count     (inflight_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_spec = '0;
        m_q.delete();
        m_rec = 0;
        m_hw  = 0;
        m_din = '0;
    endtask

    // One clock edge of the reference behaviour, applied to the driven inputs.
    task automatic model_step();
        logic [HW-1:0] old;
        bit            flushed;
        old     = m_spec;
        flushed = 0;
        if (m_rec) begin
            m_rec = 0;
        end else begin
            if (rv && m_q.size() > 0) begin
                if (rm) begin
                    m_spec  = (m_q[0] << 1) | HW'(rt);
                    m_q.delete();
                    m_rec   = 1;
                    flushed = 1;
                end else begin
                    void'(m_q.pop_front());
                end
            end
            if (pv && !flushed && m_q.size() < DP) begin
                m_q.push_back(m_spec);
                m_spec = (m_spec << 1) | HW'(pt);
            end
        end
        m_hw  = (m_spec != old);
        m_din = m_spec;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".spec"},  32'(spec_history),   32'(m_spec));
        chk({tag, ".count"}, 32'(inflight_count), 32'(m_q.size()));
        chk({tag, ".stall"}, 32'(stall),          32'(m_rec || m_q.size() == DP));
        chk({tag, ".hw"},    32'(hist_write),     32'(m_hw));
        chk({tag, ".din"},   32'(hist_datain),    32'(m_din));
    endtask

    // Drive one cycle of inputs (called at negedge), step DUT and model, check at next negedge.
    task automatic cyc(input string tag, input logic ipv, input logic ipt, input logic irv,
                       input logic irt, input logic irm);
        pv = ipv; pt = ipt; rv = irv; rt = irt; rm = irm;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset();
        pv = 0; pt = 0; rv = 0; rt = 0; rm = 0;
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        check_all("rst");
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // Predict T,N,T
        cyc("s1a", 1, 1, 0, 0, 0); chk("s1a.val", 32'(spec_history), 32'h01);
        cyc("s1b", 1, 0, 0, 0, 0); chk("s1b.val", 32'(spec_history), 32'h02);
        cyc("s1c", 1, 1, 0, 0, 0); chk("s1c.val", 32'(spec_history), 32'h05);
        chk("s1.cnt", 32'(inflight_count), 32'd3);
        // Mispredict of the oldest (snapshot 0x00, actual N) with a wrong-path predict
        cyc("s4", 1, 1, 1, 0, 1);
        chk("s4.val", 32'(spec_history), 32'h00);
        chk("s4.stall", 32'(stall), 32'd1);
        chk("s4.hw", 32'(hist_write), 32'd1);
        cyc("s4r", 1, 1, 1, 0, 0);   // ignored during recovery
        chk("s4r.stall", 32'(stall), 32'd0);

        do_reset();
        cyc("s3a", 1, 1, 0, 0, 0);
        cyc("s3b", 1, 0, 0, 0, 0);
        cyc("s3c", 1, 1, 0, 0, 0);
        cyc("s3", 0, 0, 1, 1, 0);
        chk("s3.cnt", 32'(inflight_count), 32'd2);
        chk("s3.val", 32'(spec_history), 32'h05);
        chk("s3.hw", 32'(hist_write), 32'd0);

        do_reset();
        for (int i = 0; i < 4; i++) cyc("s2p", 1, 1, 0, 0, 0);
        chk("s2.full", 32'(stall), 32'd1);
        cyc("s2drop", 1, 1, 0, 0, 0);
        chk("s2.val", 32'(spec_history), 32'h0F);
        chk("s2.cnt", 32'(inflight_count), 32'd4);
        // Full: predict N plus a correct resolve
        cyc("s5", 1, 0, 1, 1, 0);
        chk("s5.cnt", 32'(inflight_count), 32'd4);
        chk("s5.val", 32'(spec_history), 32'h1E);
        chk("s5.stall", 32'(stall), 32'd1);

        // Async reset in the middle of RECOVER
        cyc("s6m", 0, 0, 1, 0, 1);
        chk("s6.rec", 32'(stall), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("s6.stall", 32'(stall), 32'd0);
        chk("s6.hw", 32'(hist_write), 32'd0);
        chk("s6.spec", 32'(spec_history), 32'd0);
        chk("s6.cnt", 32'(inflight_count), 32'd0);
        model_reset();
        @(negedge clk);
        check_all("s6post");
        reset = 1'b0;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic r_misp;
            r_misp = ($urandom_range(0, 5) == 0);
            cyc("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), r_misp);
            if (i == 200) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time limit so the bench always terminates
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
